// File: rtl/mdio_master.sv
// Clause 22 MDIO management initiator: generates MDC, serialises one read or
// write frame per accepted request and returns one response per frame.
module mdio_master #(
  parameter int unsigned MDC_DIV = 8,
  parameter int unsigned PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phyad,
  input  logic [4:0]  req_regad,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mdc,
  output logic        mdo,
  output logic        mdo_en,
  input  logic        mdi
);

  typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA} state_t;

  localparam int unsigned      DIV_W    = $clog2(2 * MDC_DIV);
  localparam logic [DIV_W-1:0] RISE_AT  = DIV_W'(MDC_DIV - 1);
  localparam logic [DIV_W-1:0] FALL_AT  = DIV_W'(2 * MDC_DIV - 1);
  localparam logic [5:0]       PRE_LAST = 6'(PRE_LEN - 1);

  state_t           state_q, state_d;
  logic [5:0]       bit_q, bit_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             wr_q, wr_d;
  logic [31:0]      tx_q, tx_d;
  logic [15:0]      rx_q, rx_d;
  logic             ta_err_q, ta_err_d;
  logic [1:0]       sync_q;
  logic             mdc_q, mdc_d;
  logic             mdo_q, mdo_d;
  logic             mdo_en_q, mdo_en_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [15:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic             rise, bit_end, last, done;
  logic [1:0]       drv;

  // Returns {mdo, mdo_en} for a frame position; tx holds ST,OP,PHYAD,REGAD,TA,DATA.
  function automatic logic [1:0] bit_drive(state_t st, logic [5:0] cnt,
                                           logic wr, logic [31:0] tx);
    logic [5:0] pos;
    pos = (st == TA) ? cnt + 6'd14 : (st == DATA) ? cnt + 6'd16 : cnt;
    case (st)
      PRE:      bit_drive = 2'b11;
      HDR:      bit_drive = {tx[5'd31 - pos[4:0]], 1'b1};
      TA, DATA: begin
        if (!wr)            bit_drive = 2'b10;
        else if (pos >= 32) bit_drive = 2'b11;
        else                bit_drive = {tx[5'd31 - pos[4:0]], 1'b1};
      end
      default:  bit_drive = 2'b10;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      bit_q       <= '0;
      div_q       <= '0;
      wr_q        <= 1'b0;
      tx_q        <= '0;
      rx_q        <= '0;
      ta_err_q    <= 1'b0;
      sync_q      <= '0;
      mdc_q       <= 1'b0;
      mdo_q       <= 1'b1;
      mdo_en_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_q       <= bit_d;
      div_q       <= div_d;
      wr_q        <= wr_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      ta_err_q    <= ta_err_d;
      sync_q      <= {sync_q[0], mdi};
      mdc_q       <= mdc_d;
      mdo_q       <= mdo_d;
      mdo_en_q    <= mdo_en_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // DATA runs 48 bit times: 16 data bits then 32 idle-high bits, which pads
  // every frame to PRE_LEN+64 MDC periods.
  always_comb begin
    rise    = (state_q != IDLE) && (div_q == RISE_AT);
    bit_end = (state_q != IDLE) && (div_q == FALL_AT);
    case (state_q)
      PRE:     last = (bit_q == PRE_LAST);
      HDR:     last = (bit_q == 6'd13);
      TA:      last = (bit_q == 6'd1);
      DATA:    last = (bit_q == 6'd47);
      default: last = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    div_d    = div_q;
    wr_d     = wr_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    ta_err_d = ta_err_q;
    done     = 1'b0;
    if (state_q == IDLE) begin
      if (req_valid) begin
        state_d = (PRE_LEN == 0) ? HDR : PRE;
        bit_d   = '0;
        div_d   = '0;
        wr_d    = req_write;
        tx_d    = {2'b01, req_write ? 2'b01 : 2'b10, req_phyad, req_regad, 2'b10, req_wdata};
      end
    end else begin
      div_d = bit_end ? '0 : div_q + 1'b1;
      if (rise) begin
        if (state_q == TA && bit_q == 6'd1)   ta_err_d = sync_q[1];
        if (state_q == DATA && bit_q < 6'd16) rx_d = {rx_q[14:0], sync_q[1]};
      end
      if (bit_end) begin
        bit_d = last ? '0 : bit_q + 1'b1;
        if (last) begin
          case (state_q)
            PRE:     state_d = HDR;
            HDR:     state_d = TA;
            TA:      state_d = DATA;
            default: begin
              state_d = IDLE;
              done    = 1'b1;
            end
          endcase
        end
      end
    end
  end

  always_comb begin
    mdc_d       = mdc_q;
    mdo_d       = mdo_q;
    mdo_en_d    = mdo_en_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    drv         = bit_drive(state_d, bit_d, wr_d, tx_d);
    if (state_q == IDLE) begin
      mdc_d = 1'b0;
      if (req_valid) {mdo_d, mdo_en_d} = drv;
      else           {mdo_d, mdo_en_d} = 2'b10;
    end else begin
      if (rise) mdc_d = 1'b1;
      if (bit_end) begin
        mdc_d = 1'b0;
        if (done) begin
          {mdo_d, mdo_en_d} = 2'b10;
          rsp_valid_d       = 1'b1;
          if (wr_q) begin
            rsp_err_d = 1'b0;
          end else begin
            rsp_rdata_d = rx_q;
            rsp_err_d   = ta_err_q;
          end
        end else begin
          {mdo_d, mdo_en_d} = drv;
        end
      end
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mdc       = mdc_q;
  assign mdo       = mdo_q;
  assign mdo_en    = mdo_en_q;

endmodule

// File: tb/tb_mdio_master.sv
// Bench for mdio_master: two instances (MDC_DIV=4/PRE_LEN=32 and MDC_DIV=3/PRE_LEN=0)
// share stimulus; frames are checked bit-by-bit against a frame model and PHY responder.
module tb_mdio_master;

  localparam int unsigned DA = 4, PA = 32, DB = 3, PB = 0;

  typedef struct {
    logic        wr;
    logic [4:0]  phyad;
    logic [4:0]  regad;
    logic [15:0] wdata;
    logic [15:0] phy_data;
    logic        ta2;
  } req_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_write, mdi;
  logic [4:0]  req_phyad, req_regad;
  logic [15:0] req_wdata;
  logic        va, vb;
  logic        rdy_a, rv_a, er_a, mdc_a, mdo_a, en_a;
  logic        rdy_b, rv_b, er_b, mdc_b, mdo_b, en_b;
  logic [15:0] rd_a, rd_b;
  logic        req_ready, rsp_valid, rsp_err, mdc, mdo, mdo_en;
  logic [15:0] rsp_rdata;

  int          sel = 0;
  int          cur_d = DA, cur_p = PA;
  int          cyc = 0;
  int          n_checks = 0, n_errors = 0;
  int          acc_q[$];
  int          acc_log[$];
  logic [15:0] exp_rdata[2];
  logic        exp_err[2];
  int          c1, c2, r1, r2, e, t, cnt;
  req_t        rq, rq2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign va = req_valid && (sel == 0);
  assign vb = req_valid && (sel == 1);

  mdio_master #(.MDC_DIV(DA), .PRE_LEN(PA)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .req_valid(va), .req_ready(rdy_a),
    .req_write(req_write), .req_phyad(req_phyad), .req_regad(req_regad),
    .req_wdata(req_wdata), .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(er_a),
    .mdc(mdc_a), .mdo(mdo_a), .mdo_en(en_a), .mdi(mdi)
  );

  mdio_master #(.MDC_DIV(DB), .PRE_LEN(PB)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .req_valid(vb), .req_ready(rdy_b),
    .req_write(req_write), .req_phyad(req_phyad), .req_regad(req_regad),
    .req_wdata(req_wdata), .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(er_b),
    .mdc(mdc_b), .mdo(mdo_b), .mdo_en(en_b), .mdi(mdi)
  );

  assign req_ready = (sel == 1) ? rdy_b : rdy_a;
  assign rsp_valid = (sel == 1) ? rv_b  : rv_a;
  assign rsp_rdata = (sel == 1) ? rd_b  : rd_a;
  assign rsp_err   = (sel == 1) ? er_b  : er_a;
  assign mdc       = (sel == 1) ? mdc_b : mdc_a;
  assign mdo       = (sel == 1) ? mdo_b : mdo_a;
  assign mdo_en    = (sel == 1) ? en_b  : en_a;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic use_dut(input int s);
    sel   = s;
    cur_d = (s == 1) ? DB : DA;
    cur_p = (s == 1) ? PB : PA;
    #1;
  endtask

  function automatic req_t mk(input logic wr, input logic [4:0] pa, input logic [4:0] ra,
                              input logic [15:0] wd, input logic [15:0] pd, input logic ta2);
    req_t r;
    r.wr = wr; r.phyad = pa; r.regad = ra; r.wdata = wd; r.phy_data = pd; r.ta2 = ta2;
    return r;
  endfunction

  // Expected mdo/mdo_en per bit time and the mdi value the PHY presents.
  function automatic void model_frame(input req_t r, input int p, output logic [95:0] em,
                                      output logic [95:0] ee, output logic [95:0] dv);
    logic [13:0] hdr;
    int k;
    hdr = {2'b01, r.wr ? 2'b01 : 2'b10, r.phyad, r.regad};
    em = '0; ee = '0; dv = '1;
    for (int n = 0; n < p + 64; n++) begin
      k = n - p;
      if (n < p) begin
        em[n] = 1'b1; ee[n] = 1'b1;
      end else if (k < 14) begin
        em[n] = hdr[13-k]; ee[n] = 1'b1;
      end else if (k < 16) begin
        if (r.wr) begin em[n] = (k == 14); ee[n] = 1'b1; end
        else begin em[n] = 1'b1; ee[n] = 1'b0; dv[n] = (k == 15) ? r.ta2 : 1'b1; end
      end else if (k < 32) begin
        if (r.wr) begin em[n] = r.wdata[31-k]; ee[n] = 1'b1; end
        else begin em[n] = 1'b1; ee[n] = 1'b0; dv[n] = r.phy_data[31-k]; end
      end else begin
        em[n] = 1'b1; ee[n] = r.wr;
      end
    end
  endfunction

  task automatic send(input req_t r);
    int tt;
    req_write = r.wr; req_phyad = r.phyad; req_regad = r.regad; req_wdata = r.wdata;
    req_valid = 1'b1;
    tt = 0;
    do begin @(negedge clk); tt++; end while (req_ready !== 1'b1 && tt < 3000);
    if (req_ready !== 1'b1) begin
      check_eq("accept_timeout", 96'(tt), 96'(0));
      req_valid = 1'b0;
      return;
    end
    acc_q.push_back(cyc + 1);
    acc_log.push_back(cyc + 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic collect(input req_t r, output int rsp_cyc, output int rise0);
    int tt, ea, mism, nb;
    logic [95:0] em, ee, dv, om, oe;
    nb = cur_p + 64; rsp_cyc = -1; rise0 = -1;
    tt = 0;
    while (acc_q.size() == 0 && tt < 4000) begin @(negedge clk); tt++; end
    if (acc_q.size() == 0) begin check_eq("no_accept", 96'(0), 96'(1)); return; end
    ea = acc_q.pop_front();
    model_frame(r, cur_p, em, ee, dv);
    om = '0; oe = '0; mism = 0; mdi = 1'b1;
    for (int n = 0; n < nb; n++) begin
      tt = 0;
      while (mdc !== 1'b1 && tt < 4 * cur_d + 4) begin @(negedge clk); tt++; end
      if (mdc !== 1'b1) begin check_eq("mdc_rise_timeout", 96'(n), 96'(nb)); return; end
      if (n == 0) rise0 = cyc;
      if (cyc != ea + n * 2 * cur_d + cur_d) mism++;
      om[n] = mdo; oe[n] = mdo_en;
      tt = 0;
      while (mdc !== 1'b0 && tt < 4 * cur_d + 4) begin @(negedge clk); tt++; end
      if (mdc !== 1'b0) begin check_eq("mdc_fall_timeout", 96'(n), 96'(nb)); return; end
      if (n < nb - 1) mdi = dv[n+1];
    end
    rsp_cyc = cyc;
    if (r.wr) exp_err[sel] = 1'b0;
    else begin exp_rdata[sel] = r.phy_data; exp_err[sel] = r.ta2; end
    check_eq("first_rise_cyc", 96'(rise0), 96'(ea + cur_d));
    check_eq("mdc_timing_slips", 96'(mism), 96'(0));
    check_eq("mdo_bits", om, em);
    check_eq("mdo_en_bits", oe, ee);
    check_eq("rsp_valid", 96'(rsp_valid), 96'(1));
    check_eq("rsp_cyc", 96'(rsp_cyc), 96'(ea + nb * 2 * cur_d));
    check_eq("done_pins", 96'({mdo, mdo_en, req_ready}), 96'(3'b101));
    check_eq("rsp_rdata", 96'(rsp_rdata), 96'(exp_rdata[sel]));
    check_eq("rsp_err", 96'(rsp_err), 96'(exp_err[sel]));
    @(negedge clk);
    check_eq("rsp_pulse", 96'(rsp_valid), 96'(0));
  endtask

  task automatic do_frame(input req_t r);
    int a, b;
    fork
      send(r);
      collect(r, a, b);
    join
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_rdata[0] = '0; exp_rdata[1] = '0; exp_err[0] = 1'b0; exp_err[1] = 1'b0;
    reset_n = 1'b0; mdi = 1'b1; req_write = 1'b1;
    req_phyad = '0; req_regad = '0; req_wdata = '0;
    req_valid = 1'b1;
    repeat (4) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      use_dut(s);
      check_eq("reset_pins", 96'({mdc, mdo, mdo_en, rsp_valid, rsp_err, req_ready}),
               96'(6'b010001));
      check_eq("reset_rdata", 96'(rsp_rdata), 96'(0));
    end
    use_dut(0);
    req_valid = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (5) @(negedge clk);
    check_eq("post_reset_idle", 96'({mdc, req_ready}), 96'(2'b01));

    // 1: write, full preamble
    do_frame(mk(1'b1, 5'h01, 5'h00, 16'h8000, 16'h0000, 1'b0));
    // 2: read with PHY answering 0x0141
    do_frame(mk(1'b0, 5'h1F, 5'h02, 16'h0000, 16'h0141, 1'b0));
    // 3: read with nobody driving mdi
    do_frame(mk(1'b0, 5'h05, 5'h11, 16'h0000, 16'hFFFF, 1'b1));

    // 4: write then read queued with req_valid held
    rq  = mk(1'b1, 5'h0A, 5'h1B, 16'h5A3C, 16'h0000, 1'b0);
    rq2 = mk(1'b0, 5'h13, 5'h07, 16'h0000, 16'hBEEF, 1'b0);
    fork
      begin send(rq); send(rq2); end
      begin collect(rq, c1, r1); collect(rq2, c2, r2); end
    join
    check_eq("b2b_accept_cyc", 96'(acc_log[acc_log.size()-1]), 96'(c1 + 1));
    check_eq("b2b_mdc_low_gap", 96'(r2 - c1), 96'(cur_d + 1));

    // 5: reset during bit 40 of a write
    rq = mk(1'b1, 5'h02, 5'h03, 16'h1234, 16'h0000, 1'b0);
    fork
      send(rq);
      begin
        t = 0;
        while (acc_q.size() == 0 && t < 4000) begin @(negedge clk); t++; end
        e = (acc_q.size() != 0) ? acc_q.pop_front() : cyc;
        t = 0;
        while (cyc < e + 80 * cur_d + 2 && t < 2000) begin @(negedge clk); t++; end
        reset_n = 1'b0;
        #1;
        check_eq("abort_pins", 96'({mdc, mdo, mdo_en, rsp_valid, req_ready}), 96'(5'b01001));
      end
    join
    exp_rdata[0] = '0; exp_err[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    repeat (800) begin @(negedge clk); if (rsp_valid === 1'b1 || mdc === 1'b1) cnt++; end
    check_eq("abort_no_activity", 96'(cnt), 96'(0));
    do_frame(mk(1'b0, 5'h1C, 5'h1E, 16'h0000, 16'h7E81, 1'b0));

    // randomized frames
    for (int i = 0; i < 4; i++) begin
      rq = mk(1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom), 16'($urandom),
              16'($urandom), 1'($urandom_range(0, 3) == 0));
      do_frame(rq);
    end

    // 6: no preamble, MDC_DIV=3; busy pulses must be ignored
    use_dut(1);
    rq = mk(1'b1, 5'h11, 5'h0F, 16'hC3A5, 16'h0000, 1'b0);
    fork
      begin
        send(rq);
        req_write = 1'b0; req_phyad = 5'h1F; req_wdata = 16'h0F0F;
        repeat (3) begin
          repeat (40) @(negedge clk);
          req_valid = 1'b1;
          check_eq("busy_ready", 96'(req_ready), 96'(0));
          @(negedge clk);
          req_valid = 1'b0;
        end
      end
      collect(rq, c1, r1);
    join
    cnt = 0;
    repeat (20) begin @(negedge clk); if (mdc !== 1'b0 || req_ready !== 1'b1) cnt++; end
    check_eq("idle_after_pulses", 96'(cnt), 96'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
